// File: rtl/control_pkg.sv
// Shared types and constants for the program-flow unit: default widths,
// the sequencer state encoding and the fault codes reported on fault_code.
package control_pkg;

  localparam int PC_WIDTH_DEF          = 8;
  localparam int INSTRUCTION_WIDTH_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_OVF      = 2'b01;
  localparam logic [1:0] FAULT_UNF      = 2'b10;
  localparam logic [1:0] FAULT_CONFLICT = 2'b11;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Push-when-full and pop-when-empty are ignored; the
// sequencer guards them and raises the matching fault instead.
module ret_stack #(
  parameter int STACK_DEPTH = 4,
  parameter int PC_WIDTH    = 8,
  localparam int DW = $clog2(STACK_DEPTH + 1),
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] din,
  output logic [PC_WIDTH-1:0] top,
  output logic                full,
  output logic                empty,
  output logic [DW-1:0]       depth
);

  logic [PC_WIDTH-1:0] mem [STACK_DEPTH];

  assign full  = (depth == DW'(STACK_DEPTH));
  assign empty = (depth == '0);
  assign top   = empty ? '0 : mem[AW'(depth - DW'(1))];

  // Contents need no reset: only entries below depth are ever read.
  always_ff @(posedge clk) begin
    if (push && !full) mem[AW'(depth)] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth <= '0;
    end else if (push && !full) begin
      depth <= depth + DW'(1);
    end else if (pop && !empty) begin
      depth <= depth - DW'(1);
    end
  end

endmodule

// File: rtl/flow_sequencer.sv
// Program-flow unit: PC, instruction register, fetch/execute FSM and a
// return-address stack for nested calls, with sticky HALT and FAULT states.
module flow_sequencer
  import control_pkg::*;
#(
  parameter int PC_WIDTH          = PC_WIDTH_DEF,
  parameter int INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEF,
  parameter int STACK_DEPTH       = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  localparam int SDW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic                         imem_ack,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_data,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]          instr_addr,
  output logic                         instr_valid,
  input  logic                         exec_done,
  input  logic                         jmp,
  input  logic                         cal,
  input  logic                         ret,
  input  logic                         halt,
  input  logic [PC_WIDTH-1:0]          jmp_addr,
  output logic [SDW-1:0]               stack_depth,
  output logic                         halted,
  output logic                         fault,
  output logic [1:0]                   fault_code,
  output state_t                       dbg_state
);

  state_t                       state, state_next;
  logic [PC_WIDTH-1:0]          pc, pc_next, pc_inc;
  logic [INSTRUCTION_WIDTH-1:0] instr_next;
  logic [1:0]                   code_next;
  logic                         push, pop, conflict;
  logic [PC_WIDTH-1:0]          stk_top;
  logic                         stk_full, stk_empty;

  ret_stack #(.STACK_DEPTH(STACK_DEPTH), .PC_WIDTH(PC_WIDTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .depth (stack_depth)
  );

  // Fetch handshake: imem_req is high for every cycle in FETCH with
  // imem_addr stable; the first cycle with imem_ack high (possibly the first
  // FETCH cycle) transfers imem_data. imem_ack outside FETCH is ignored.
  assign imem_req    = (state == ST_FETCH);
  assign imem_addr   = pc;
  assign instr_addr  = pc;
  assign instr_valid = (state == ST_EXEC);
  assign halted      = (state == ST_HALT);
  assign fault       = (state == ST_FAULT);
  assign dbg_state   = state;
  assign pc_inc      = pc + PC_WIDTH'(1);
  assign conflict    = (jmp & cal) | (jmp & ret) | (jmp & halt) |
                       (cal & ret) | (cal & halt) | (ret & halt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_VECTOR;
      instruction <= '0;
      fault_code  <= FAULT_NONE;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instruction <= instr_next;
      fault_code  <= code_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instruction;
    code_next  = fault_code;
    push       = 1'b0;
    pop        = 1'b0;
    case (state)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_next = imem_data;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          if (conflict) begin
            state_next = ST_FAULT;
            code_next  = FAULT_CONFLICT;
          end else if (halt) begin
            state_next = ST_HALT;
          end else if (ret) begin
            if (stk_empty) begin
              state_next = ST_FAULT;
              code_next  = FAULT_UNF;
            end else begin
              pop        = 1'b1;
              pc_next    = stk_top;
              state_next = ST_FETCH;
            end
          end else if (cal) begin
            if (stk_full) begin
              state_next = ST_FAULT;
              code_next  = FAULT_OVF;
            end else begin
              push       = 1'b1;
              pc_next    = jmp_addr;
              state_next = ST_FETCH;
            end
          end else if (jmp) begin
            pc_next    = jmp_addr;
            state_next = ST_FETCH;
          end else begin
            pc_next    = pc_inc;
            state_next = ST_FETCH;
          end
        end
      end
      default: ; // HALT and FAULT hold everything until reset
    endcase
  end

endmodule

// File: tb/tb_flow_sequencer.sv
// Directed bench for flow_sequencer: a vector table for sequential fetch,
// nested calls/returns, PC wrap and halt, plus hand sequences for faults
// and an asynchronous reset in the middle of a fetch.
module tb_flow_sequencer;
  import control_pkg::*;

  localparam int PW = 8;
  localparam int IW = 24;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req, imem_ack;
  logic [PW-1:0] imem_addr, instr_addr, jmp_addr;
  logic [IW-1:0] imem_data, instruction;
  logic          instr_valid, exec_done, jmp, cal, ret, halt;
  logic [2:0]    stack_depth;
  logic          halted, fault;
  logic [1:0]    fault_code;
  state_t        dbg_state;

  int errors = 0;
  int checks = 0;
  logic [IW-1:0] exp_q[$];

  typedef struct {
    int          dly;
    logic [IW-1:0] data;
    logic [PW-1:0] exp_addr;
    logic        j, c, r, h;
    logic [PW-1:0] tgt;
    logic [2:0]  exp_depth;
  } vec_t;

  vec_t vecs[11];

  flow_sequencer #(.PC_WIDTH(PW), .INSTRUCTION_WIDTH(IW), .STACK_DEPTH(SD),
                   .RESET_VECTOR(8'h00)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .instruction(instruction),
    .instr_addr(instr_addr), .instr_valid(instr_valid), .exec_done(exec_done),
    .jmp(jmp), .cal(cal), .ret(ret), .halt(halt), .jmp_addr(jmp_addr),
    .stack_depth(stack_depth), .halted(halted), .fault(fault),
    .fault_code(fault_code), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // driver: wait (bounded) for the request, answer after dly cycles
  task automatic fetch(input int dly, input logic [IW-1:0] data, input logic [PW-1:0] exp_addr);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", imem_req, 1);
    if (!imem_req) return;
    chk("fetch_addr", imem_addr, exp_addr);
    chk("valid_in_fetch", instr_valid, 0);
    repeat (dly) @(negedge clk);
    chk("fetch_addr_stable", imem_addr, exp_addr);
    imem_ack  = 1'b1;
    imem_data = data;
    exp_q.push_back(data);
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = IW'($urandom);
    chk("instr_valid", instr_valid, 1);
    chk("instruction", instruction, exp_q.pop_front());
    chk("instr_addr", instr_addr, exp_addr);
  endtask

  // driver: one stall cycle with junk flow bits, then exec_done with the real ones
  task automatic exec_step(input logic j, input logic c, input logic r, input logic h,
                           input logic [PW-1:0] tgt);
    logic [IW-1:0] held;
    held = instruction;
    {jmp, cal, ret, halt} = 4'($urandom_range(0, 15));
    jmp_addr  = PW'($urandom);
    exec_done = 1'b0;
    @(negedge clk);
    chk("exec_wait_valid", instr_valid, 1);
    chk("exec_wait_hold", instruction, held);
    jmp = j; cal = c; ret = r; halt = h;
    jmp_addr  = tgt;
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    {jmp, cal, ret, halt} = 4'b0;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_data = '0; exec_done = 1'b0;
    jmp = 1'b0; cal = 1'b0; ret = 1'b0; halt = 1'b0; jmp_addr = '0;

    //               dly data        addr   j c r h  tgt    depth
    vecs[0]  = '{0, 24'h100001, 8'h00, 0,0,0,0, 8'h00, 3'd0};
    vecs[1]  = '{3, 24'h100002, 8'h01, 0,0,0,0, 8'h00, 3'd0};
    vecs[2]  = '{1, 24'h100003, 8'h02, 0,1,0,0, 8'h10, 3'd1};
    vecs[3]  = '{0, 24'h200010, 8'h10, 0,1,0,0, 8'h20, 3'd2};
    vecs[4]  = '{2, 24'h300020, 8'h20, 0,1,0,0, 8'h30, 3'd3};
    vecs[5]  = '{0, 24'h400030, 8'h30, 0,0,1,0, 8'h00, 3'd2};
    vecs[6]  = '{1, 24'h500021, 8'h21, 0,0,1,0, 8'h00, 3'd1};
    vecs[7]  = '{0, 24'h600011, 8'h11, 0,0,1,0, 8'h00, 3'd0};
    vecs[8]  = '{0, 24'h700003, 8'h03, 1,0,0,0, 8'hFF, 3'd0};
    vecs[9]  = '{2, 24'h8000FF, 8'hFF, 0,0,0,0, 8'h00, 3'd0};
    vecs[10] = '{0, 24'h900000, 8'h00, 0,0,0,1, 8'h00, 3'd0};

    // reset state
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_instr", instruction, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_depth", stack_depth, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("idle_no_req", imem_req, 0);

    // sequential fetch, nested calls, wrap, halt
    for (int i = 0; i < 11; i++) begin
      fetch(vecs[i].dly, vecs[i].data, vecs[i].exp_addr);
      exec_step(vecs[i].j, vecs[i].c, vecs[i].r, vecs[i].h, vecs[i].tgt);
      chk($sformatf("depth_v%0d", i), stack_depth, vecs[i].exp_depth);
      if (vecs[i].h) begin
        chk("halted", halted, 1);
        chk("halt_no_req", imem_req, 0);
      end else begin
        chk($sformatf("b2b_req_v%0d", i), imem_req, 1);
      end
    end
    imem_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("halt_sticky_req", imem_req, 0);
      chk("halt_sticky_valid", instr_valid, 0);
      chk("halt_sticky", halted, 1);
    end
    imem_ack = 1'b0;
    chk("halt_pc_frozen", instr_addr, 8'h00);

    // overflow: fifth nested call
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fetch(i % 3, IW'(32'hA00000 + i), PW'(i * 16));
      exec_step(0, 1, 0, 0, PW'((i + 1) * 16));
    end
    chk("ovf_fault", fault, 1);
    chk("ovf_code", fault_code, FAULT_OVF);
    chk("ovf_depth", stack_depth, 4);
    chk("ovf_pc", instr_addr, 8'h40);
    repeat (3) begin
      @(negedge clk);
      chk("ovf_no_req", imem_req, 0);
    end

    // underflow
    do_reset();
    fetch(2, 24'hB00000, 8'h00);
    exec_step(0, 0, 1, 0, 8'h00);
    chk("unf_fault", fault, 1);
    chk("unf_code", fault_code, FAULT_UNF);
    chk("unf_halted", halted, 0);
    chk("unf_no_req", imem_req, 0);

    // conflicting requests
    do_reset();
    fetch(1, 24'hC00000, 8'h00);
    exec_step(1, 1, 0, 0, 8'h77);
    chk("cfl_fault", fault, 1);
    chk("cfl_code", fault_code, FAULT_CONFLICT);
    chk("cfl_depth", stack_depth, 0);
    chk("cfl_pc", instr_addr, 8'h00);

    // asynchronous reset mid-fetch, stale ack during IDLE
    do_reset();
    fetch(0, 24'hD00000, 8'h00);
    exec_step(1, 0, 0, 0, 8'h42);
    chk("mid_req", imem_req, 1);
    chk("mid_addr", imem_addr, 8'h42);
    #2 rst = 1'b1;
    #1;
    chk("async_req", imem_req, 0);
    chk("async_addr", imem_addr, 8'h00);
    chk("async_instr", instruction, 0);
    @(negedge clk);
    rst = 1'b0;
    imem_ack  = 1'b1;
    imem_data = 24'hBADBAD;
    #1;
    chk("post_rst_idle", dbg_state, ST_IDLE);
    chk("post_rst_no_req", imem_req, 0);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("stale_ack_req", imem_req, 1);
    chk("stale_ack_valid", instr_valid, 0);
    chk("stale_ack_instr", instruction, 0);
    fetch(0, 24'hE00000, 8'h00);
    exec_step(0, 0, 0, 0, 8'h00);
    chk("post_rst_next", imem_addr, 8'h01);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
